// File: rtl/riscv_pkg.sv
// Shared RV32I fetch-side types and constants.
// IFU_MISALIGN_CHECK_EN adds a per-entry fault bit to fetch_entry_t.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } ifu_state_t;

  typedef struct packed {
`ifdef IFU_MISALIGN_CHECK_EN
    logic            fault;
`endif
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with flush and occupancy count.
// Push while full is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch: PC, imem request/response handshake, in-order fetch queue.
// IFU_MISALIGN_CHECK_EN: misaligned redirects enqueue a fault entry and add the id_fault port.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_addr
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        id_fault
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  ifu_state_t      state_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   live_q, live_d, drop_q, drop_d;
  logic [CW-1:0]   ent_cnt, adr_cnt;
  logic [CW:0]     occ, inflight;
  fetch_entry_t    ent_din, ent_dout;
  logic [XLEN-1:0] adr_dout;
  logic            ent_push, ent_empty, ent_full, adr_full, adr_empty;
  logic            req_hs, rsp_keep, deq, stall;

  assign id_valid = !ent_empty && !redirect_valid;
  assign deq      = id_valid && id_ready;
  assign id_instr = id_valid ? ent_dout.instr : NOP_INSTR;
  assign id_addr  = id_valid ? ent_dout.addr  : '0;

  // The head leaving this cycle frees its slot, which keeps one fetch per cycle at DEPTH=2.
  assign occ      = (CW + 1)'(ent_cnt) + (CW + 1)'(live_q) - (CW + 1)'(deq);
  assign inflight = (CW + 1)'(live_q) + (CW + 1)'(drop_q);

  assign imem_req_valid = (state_q == ST_RUN) && !redirect_valid && !stall &&
                          (occ < DEPTH_C) && (inflight < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
  end

  assign stall    = misalign_q;
  assign id_fault = id_valid && ent_dout.fault;
`else
  logic unused_ok;
  assign stall     = 1'b0;
  assign unused_ok = ^{ent_full, adr_full, adr_empty, adr_cnt, redirect_pc[1:0]};
`endif

  always_comb begin
    ent_push       = rsp_keep;
    ent_din        = '0;
    ent_din.addr   = adr_dout;
    ent_din.instr  = imem_rsp_data;
`ifdef IFU_MISALIGN_CHECK_EN
    // The fault entry lands in the cycle after the redirect, once the queue has been flushed.
    if ((state_q == ST_REDIR) && misalign_q) begin
      ent_push      = 1'b1;
      ent_din.fault = 1'b1;
      ent_din.addr  = pc_q;
      ent_din.instr = NOP_INSTR;
    end
`endif
  end

  always_comb begin
    pc_d   = pc_q;
    live_d = live_q;
    drop_d = drop_q;
    if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
      pc_d = redirect_pc;
`else
      pc_d = {redirect_pc[31:2], 2'b00};
`endif
      live_d = '0;
      // Everything still in flight becomes wrong-path; a beat arriving now is one of them.
      drop_d = drop_q + live_q - CW'(imem_rsp_valid);
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      live_d = live_q + CW'(req_hs) - CW'(rsp_keep);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      live_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= redirect_valid ? ST_REDIR : ST_RUN;
      pc_q    <= pc_d;
      live_q  <= live_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (ent_push),
    .din_i   (ent_din),
    .pop_i   (deq),
    .dout_o  (ent_dout),
    .full_o  (ent_full),
    .empty_o (ent_empty),
    .count_o (ent_cnt)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (req_hs),
    .din_i   (pc_q),
    .pop_i   (rsp_keep),
    .dout_o  (adr_dout),
    .full_o  (adr_full),
    .empty_o (adr_empty),
    .count_o (adr_cnt)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a latency-programmable memory model and an expected-instruction queue.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_addr;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        id_fault;
`endif

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n0;
  logic        no_req = 1'b0;
  logic [31:0] exp_req_pc = 32'h0;
  exp_t        sb[$];
  mreq_t       mq[$];

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_addr        (id_addr)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .id_fault       (id_fault)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory: checks request order, answers after lat cycles, records expected output.
  initial begin
    mreq_t m;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (no_req) chk("misalign_no_req", {31'b0, imem_req_valid}, 32'h0);
        else if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
        if (imem_req_valid && imem_req_ready) begin
          mq.push_back('{addr: imem_req_addr, due: cyc + lat});
          sb.push_back('{addr: imem_req_addr, data: memf(imem_req_addr), fault: 1'b0});
          exp_req_pc = imem_req_addr + 32'd4;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(m.addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Decoder side: every consumed instruction must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (id_valid && id_ready) begin
          consumed++;
          chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'h1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("id_addr", id_addr, e.addr);
            chk("id_instr", id_instr, e.data);
`ifdef IFU_MISALIGN_CHECK_EN
            chk("id_fault", {31'b0, id_fault}, {31'b0, e.fault});
`endif
          end
        end else if (!id_valid) begin
          chk("idle_nop", id_instr, NOP);
        end
      end
    end
  end

  task automatic do_reset(input int new_lat, input logic rdy);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mq.delete();
    sb.delete();
    imem_rsp_valid = 1'b0;
    lat = new_lat;
    id_ready = rdy;
    exp_req_pc = 32'h0;
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_addr", id_addr, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = pc;
    sb.delete();
    exp_req_pc = pc;
    @(negedge clk);
    chk("redir_id_valid", {31'b0, id_valid}, 32'h0);
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;

    // Streaming after reset: BOOT cycle, then 0,4,8 back to back, decoder sees 0x0 two cycles later.
    do_reset(1, 1'b1);
    @(negedge clk);
    chk("boot_no_req", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    chk("second_req_addr", imem_req_addr, 32'h4);
    chk("second_id_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk);
    chk("third_req_addr", imem_req_addr, 32'h8);
    chk("first_id_valid", {31'b0, id_valid}, 32'h1);
    chk("first_id_addr", id_addr, 32'h0);
    @(posedge clk);
    #1;
    n0 = consumed;
    repeat (10) @(posedge clk);
    #1;
    chk("throughput", consumed - n0, 32'd10);

    // Decoder stall: queue fills, fetch stops, head holds 0x0, then drains in order.
    do_reset(1, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_id_valid", {31'b0, id_valid}, 32'h1);
      chk("stall_id_addr", id_addr, 32'h0);
      if (i >= 2) chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    n0 = consumed;
    repeat (15) @(posedge clk);
    #1;
    chk("drain_progress", {31'b0, (consumed - n0) >= 12}, 32'h1);

    // Redirect with three requests outstanding and the oldest response landing in the redirect cycle.
    do_reset(3, 1'b1);
    repeat (3) @(posedge clk);
    n0 = consumed;
    redirect(32'h0000_0100);
    chk("redir_nothing_old", consumed - n0, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("redir_resumed", {31'b0, (consumed - n0) >= 3}, 32'h1);

    // Request ready toggling: address must hold while unaccepted and advance without skips.
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      imem_req_ready = ~imem_req_ready;
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    n0 = consumed;
    repeat (8) @(posedge clk);
    #1;
    chk("toggle_progress", {31'b0, (consumed - n0) >= 5}, 32'h1);

    // PC wrap while streaming.
    redirect(32'hFFFF_FFFC);
    n0 = consumed;
    repeat (10) @(posedge clk);
    #1;
    chk("wrap_progress", {31'b0, (consumed - n0) >= 5}, 32'h1);

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned redirect: single fault entry, no memory traffic until the next redirect.
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    sb.delete();
    sb.push_back('{addr: 32'h0000_0102, data: NOP, fault: 1'b1});
    no_req = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("fault_consumed", sb.size(), 32'd0);
    no_req = 1'b0;
    n0 = consumed;
    redirect(32'h0000_0200);
    repeat (8) @(posedge clk);
    #1;
    chk("resume_progress", {31'b0, (consumed - n0) >= 4}, 32'h1);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
